// File: rtl/upload_arbiter.sv
// upload_arbiter: round-robin, packet-locking merge of the handler upload
// channels onto the single command_processor upload port. A source keeps the
// grant for as long as it holds src_req, so bytes of one packet never
// interleave with another source's bytes.
module upload_arbiter #(
  parameter int N_SRC       = 3,
  parameter int TIMEOUT_CYC = 65535,
  localparam int GW         = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     src_req,
  input  logic [8*N_SRC-1:0]   src_data,
  input  logic [8*N_SRC-1:0]   src_source,
  input  logic [N_SRC-1:0]     src_valid,
  output logic [N_SRC-1:0]     src_ready,
  output logic                 up_req,
  output logic [7:0]           up_data,
  output logic [7:0]           up_source,
  output logic                 up_valid,
  input  logic                 up_ready,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 timeout_evt
);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [15:0]   tmo_cnt_q, tmo_cnt_d;

  logic          locked;
  logic          xfer;
  logic          tmo_fire;
  logic          any_req;
  logic [GW-1:0] pick;
  logic [GW-1:0] next_ptr;

  assign locked   = (state_q == S_LOCK);
  // A reset cycle never moves a byte, even though the grant is still held.
  assign xfer     = locked & ~rst & src_valid[grant_q] & up_ready;
  assign any_req  = |src_req;
  assign next_ptr = (grant_q == GW'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
  // Release request takes precedence over a timeout landing in the same cycle.
  assign tmo_fire = locked & ~rst & src_req[grant_q] & ~xfer &
                    (TIMEOUT_CYC != 0) & (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_SRC;
      if (!found && src_req[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // State, pointer, grant and idle-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Next-state: grant on any request, hold while req stays up, one GAP cycle on release.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d   = S_LOCK;
          grant_d   = pick;
          tmo_cnt_d = '0;
        end
      end
      S_LOCK: begin
        if (!src_req[grant_q] || tmo_fire) begin
          state_d  = S_GAP;
          rr_ptr_d = next_ptr;
        end
        if (xfer) tmo_cnt_d = '0;
        else if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pass-through of the granted source while locked, all zero otherwise.
  always_comb begin
    up_req      = 1'b0;
    busy        = 1'b0;
    up_data     = '0;
    up_source   = '0;
    up_valid    = 1'b0;
    src_ready   = '0;
    grant_id    = '0;
    timeout_evt = 1'b0;
    if (locked) begin
      up_req              = 1'b1;
      busy                = 1'b1;
      grant_id            = grant_q;
      up_data             = src_data[8*grant_q +: 8];
      up_source           = src_source[8*grant_q +: 8];
      up_valid            = src_valid[grant_q] & ~rst;
      src_ready[grant_q]  = up_ready & ~rst;
      timeout_evt         = tmo_fire;
    end
  end

endmodule

// File: tb/tb_upload_arbiter.sv
// Randomized scoreboard bench for upload_arbiter (3 sources, 8-cycle timeout).
// The stimulus process predicts each cycle's outputs and every accepted byte
// from an owner/pointer model and queues them; the monitor checks on negedge.
module tb_upload_arbiter;
  localparam int N   = 3;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, vld, src_ready;
  logic [7:0]   dat [N];
  logic [7:0]   tag [N];
  logic [8*N-1:0] src_data, src_source;
  logic         up_req, up_valid, up_ready, busy, timeout_evt;
  logic [7:0]   up_data, up_source;
  logic [1:0]   grant_id;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_data[8*i +: 8]   = dat[i];
      src_source[8*i +: 8] = tag[i];
    end
  end

  upload_arbiter #(.N_SRC(N), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .src_req(req), .src_data(src_data),
    .src_source(src_source), .src_valid(vld), .src_ready(src_ready),
    .up_req(up_req), .up_data(up_data), .up_source(up_source),
    .up_valid(up_valid), .up_ready(up_ready), .grant_id(grant_id),
    .busy(busy), .timeout_evt(timeout_evt)
  );

  typedef struct packed {
    logic ureq; logic [7:0] ud; logic [7:0] us; logic uv;
    logic [2:0] sr; logic [1:0] gid; logic bz; logic te;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] byte_q[$];
  int tests = 0, fails = 0;

  // Reference model: who owns the port (-1 = nobody), whether we are in the
  // post-release dead cycle, where the next search starts, and how long the
  // owner has gone without moving a byte.
  int m_own = -1, m_ptr = 0, m_cnt = 0;
  bit m_gap = 0;
  // Source drivers: bytes left in the current packet, and whether the source's
  // byte was taken this cycle.
  int rem [N];
  bit took [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    tests++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    end
  endtask

  task automatic release_owner();
    m_ptr = (m_own + 1) % N;
    m_own = -1;
    m_gap = 1;
  endtask

  // Advance the model across a clock edge using the inputs held during the cycle.
  task automatic model_step();
    bit x;
    if (rst) begin
      m_own = -1; m_gap = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++)
        if (m_own < 0 && req[(m_ptr + k) % N]) begin
          m_own = (m_ptr + k) % N;
          m_cnt = 0;
        end
    end else begin
      x = vld[m_own] && up_ready;
      if (!req[m_own]) release_owner();
      else if (!x && m_cnt == TMO - 1) release_owner();
      else m_cnt = x ? 0 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
    end
  endtask

  // Expected outputs for the inputs just driven; record any byte that moves.
  task automatic push_exp();
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) took[i] = 0;
    if (m_own >= 0) begin
      e.ureq = 1; e.bz = 1; e.gid = 2'(m_own);
      e.ud = dat[m_own]; e.us = tag[m_own];
      e.uv = vld[m_own] && !rst;
      e.sr[m_own] = up_ready && !rst;
      e.te = !rst && req[m_own] && !(e.uv && up_ready) && m_cnt == TMO - 1;
      if (e.uv && up_ready) begin
        byte_q.push_back({e.us, e.ud});
        took[m_own] = 1;
        if (rem[m_own] > 0) rem[m_own]--;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle's outputs, plus the ordered stream of accepted bytes.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("up_req",      32'(up_req),      32'(e.ureq));
      chk("busy",        32'(busy),        32'(e.bz));
      chk("grant_id",    32'(grant_id),    32'(e.gid));
      chk("up_data",     32'(up_data),     32'(e.ud));
      chk("up_source",   32'(up_source),   32'(e.us));
      chk("up_valid",    32'(up_valid),    32'(e.uv));
      chk("src_ready",   32'(src_ready),   32'(e.sr));
      chk("timeout_evt", 32'(timeout_evt), 32'(e.te));
    end
    if (up_valid === 1'b1 && up_ready === 1'b1) begin
      if (byte_q.size() == 0) chk("unexpected_byte", 32'({up_source, up_data}), 32'hFFFF_FFFF);
      else chk("byte_stream", 32'({up_source, up_data}), 32'(byte_q.pop_front()));
    end
  end

  // Drive one cycle of source / sink behaviour.
  //   new_pct : chance (%) an idle source opens a packet
  //   vld_pct : chance (%) a requesting source presents a byte
  //   rdy_pct : chance (%) the sink is ready
  task automatic drive(input int c, input int new_pct, input int vld_pct, input int rdy_pct,
                       input int maxlen);
    for (int i = 0; i < N; i++) begin
      if (req[i] && rem[i] == 0) begin
        req[i] = 0; vld[i] = 0;
      end else if (!req[i] && $urandom_range(99) < new_pct) begin
        req[i] = 1;
        rem[i] = $urandom_range(maxlen, 1);
      end
      if (req[i] && (!vld[i] || took[i])) begin
        vld[i] = ($urandom_range(99) < vld_pct);
        dat[i] = (c < 10) ? 8'hA4 - 8'(rem[i]) : 8'($urandom);
      end else if (!req[i]) vld[i] = 0;
    end
    up_ready = ($urandom_range(99) < rdy_pct);
  endtask

  initial begin
    rst = 1; req = '0; vld = '0; up_ready = 0;
    for (int i = 0; i < N; i++) begin
      dat[i] = '0; tag[i] = 8'hC0 | 8'(i); rem[i] = 0; took[i] = 0;
    end
    for (int c = 0; c < 2200; c++) begin
      @(posedge clk); #1;
      model_step();
      rst = 0;
      if (c < 3) begin
        up_ready = 1;                          // idle after reset
      end else if (c == 3) begin
        req[1] = 1; rem[1] = 3;                // SPI single packet A1..A3
        drive(c, 0, 100, 100, 1);
      end else if (c < 10) begin
        drive(c, 0, 100, 100, 1);
      end else if (c == 10) begin
        for (int i = 0; i < N; i++) begin req[i] = 1; rem[i] = 2; end
        drive(c, 0, 100, 100, 1);              // simultaneous 2-byte packets
      end else if (c < 50) begin
        drive(c, 0, 100, 100, 1);
      end else if (c == 50) begin
        req[0] = 1; rem[0] = 1;
        drive(c, 0, 100, 100, 1);
      end else if (c < 70) begin
        drive(c, 0, 100, (c >= 52 && c < 62) ? 0 : 100, 1);   // backpressure window
      end else if (c == 70) begin
        req = 3'b101; rem[0] = 1; rem[2] = 1;
        drive(c, 0, 0, 100, 1);
      end else if (c < 100) begin
        drive(c, 0, 0, 100, 1);                // held req, no data: timeouts
      end else if (c < 110) begin
        drive(c, 0, 100, 100, 1);
      end else if (c == 110) begin
        req[1] = 1; rem[1] = 4;
        drive(c, 0, 100, 100, 1);
      end else if (c < 130) begin
        drive(c, 0, 100, 100, 1);
        if (c == 113) rst = 1;                 // reset mid-packet
      end else begin
        drive(c, 25, 75, 75, 5);
        if ($urandom_range(299) == 0) rst = 1;
      end
      push_exp();
    end
    @(posedge clk); #1;
    req = '0; vld = '0;
    @(negedge clk); @(negedge clk);
    chk("exp_queue_drained",  32'(exp_q.size()),  32'd0);
    chk("byte_queue_drained", 32'(byte_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
